// File: rtl/px_mode_router.sv
// Per-frame pixel router: grey/channel-0 to an external Sobel engine, grey out, or raw passthrough.
// Optional build macro PX_MODE_ROUTER_THRESHOLD_EN adds threshold_i and binarises the mode-10 grey output.
module px_mode_router #(
   parameter int PX_W     = 8,
   parameter int FRAME_PX = 64
) (
   input  logic              clk_i,
   input  logic              nreset_i,
   input  logic [1:0]        mode_i,
   input  logic              frame_start_i,
   input  logic              px_rdy_i,
   input  logic [3*PX_W-1:0] in_pixel_i,
`ifdef PX_MODE_ROUTER_THRESHOLD_EN
   input  logic [PX_W-1:0]   threshold_i,
`endif
   output logic [PX_W-1:0]   sobel_px_o,
   output logic              sobel_rdy_o,
   input  logic [PX_W-1:0]   sobel_px_i,
   input  logic              sobel_rdy_i,
   output logic [3*PX_W-1:0] out_pixel_o,
   output logic              px_rdy_o,
   output logic              frame_done_o,
   output logic [1:0]        mode_o
);

   localparam int CNT_W = $clog2(FRAME_PX);

   logic [1:0]        mode_q;
   logic [1:0]        eff_mode;
   logic              s1_valid;
   logic [3*PX_W-1:0] s1_px;
   logic [1:0]        s1_mode;
   logic [PX_W+1:0]   gray_sum;
   logic [PX_W-1:0]   gray;
   logic [PX_W-1:0]   gray_level;
   logic [CNT_W-1:0]  px_cnt;
   logic              last_px;

   assign eff_mode = frame_start_i ? mode_i : mode_q;
   assign mode_o   = mode_q;
   assign last_px  = (px_cnt == CNT_W'(FRAME_PX - 1));

   // R + 2G + B never overflows PX_W+2 bits
   assign gray_sum = {2'b00, s1_px[3*PX_W-1:2*PX_W]}
                   + {1'b0, s1_px[2*PX_W-1:PX_W], 1'b0}
                   + {2'b00, s1_px[PX_W-1:0]};
   assign gray     = PX_W'(gray_sum >> 2);

`ifdef PX_MODE_ROUTER_THRESHOLD_EN
   always_comb begin
      gray_level = gray;
      if (threshold_i != '0)
         gray_level = (gray >= threshold_i) ? '1 : '0;
   end
`else
   assign gray_level = gray;
`endif

   // Sobel request path is driven straight from stage 1 under the pixel's own captured mode
   assign sobel_rdy_o = s1_valid && !s1_mode[1];
   assign sobel_px_o  = s1_mode[1] ? '0 : (s1_mode[0] ? s1_px[PX_W-1:0] : gray);

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         mode_q       <= 2'b00;
         s1_valid     <= 1'b0;
         s1_px        <= '0;
         s1_mode      <= 2'b00;
         out_pixel_o  <= '0;
         px_rdy_o     <= 1'b0;
         frame_done_o <= 1'b0;
         px_cnt       <= '0;
      end else begin
         px_rdy_o     <= 1'b0;
         frame_done_o <= 1'b0;
         s1_valid     <= px_rdy_i;

         if (frame_start_i)
            mode_q <= mode_i;

         if (px_rdy_i) begin
            s1_px   <= in_pixel_i;
            s1_mode <= eff_mode;
         end

         // A mode-1x pixel in stage 1 implies mode_q is 1x now, so the two loads never collide
         if (s1_valid && s1_mode[1]) begin
            out_pixel_o <= s1_mode[0] ? s1_px : {{(2*PX_W){1'b0}}, gray_level};
            px_rdy_o    <= 1'b1;
         end else if (sobel_rdy_i && !mode_q[1]) begin
            out_pixel_o <= {{(2*PX_W){1'b0}}, sobel_px_i};
            px_rdy_o    <= 1'b1;
         end

         if (frame_start_i) begin
            px_cnt <= px_rdy_i ? CNT_W'(1) : '0;
         end else if (px_rdy_i) begin
            if (last_px) begin
               px_cnt       <= '0;
               frame_done_o <= 1'b1;
            end else begin
               px_cnt <= px_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_px_mode_router.sv
// Scoreboard bench for px_mode_router: a driver pushes expected responses, a negedge monitor pops and compares.
module tb_px_mode_router;
   localparam int PX_W     = 8;
   localparam int FRAME_PX = 4;

   logic        clk_i = 1'b0;
   logic        nreset_i = 1'b0;
   logic [1:0]  mode_i = 2'b00;
   logic        frame_start_i = 1'b0;
   logic        px_rdy_i = 1'b0;
   logic [23:0] in_pixel_i = '0;
   logic [7:0]  threshold_i = '0;
   logic [7:0]  sobel_px_o;
   logic        sobel_rdy_o;
   logic [7:0]  sobel_px_i = '0;
   logic        sobel_rdy_i = 1'b0;
   logic [23:0] out_pixel_o;
   logic        px_rdy_o;
   logic        frame_done_o;
   logic [1:0]  mode_o;

   px_mode_router #(.PX_W(PX_W), .FRAME_PX(FRAME_PX)) dut (
      .clk_i        (clk_i),
      .nreset_i     (nreset_i),
      .mode_i       (mode_i),
      .frame_start_i(frame_start_i),
      .px_rdy_i     (px_rdy_i),
      .in_pixel_i   (in_pixel_i),
`ifdef PX_MODE_ROUTER_THRESHOLD_EN
      .threshold_i  (threshold_i),
`endif
      .sobel_px_o   (sobel_px_o),
      .sobel_rdy_o  (sobel_rdy_o),
      .sobel_px_i   (sobel_px_i),
      .sobel_rdy_i  (sobel_rdy_i),
      .out_pixel_o  (out_pixel_o),
      .px_rdy_o     (px_rdy_o),
      .frame_done_o (frame_done_o),
      .mode_o       (mode_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [23:0] val;
      int          cyc;
   } exp_t;

   exp_t        q_out[$];
   exp_t        q_sob[$];
   exp_t        q_mode[$];
   int          q_done[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;
   logic [23:0] last_out = '0;

   // reference model state: latched mode, pixels accepted in frame, threshold in force
   logic [1:0]  m_mode = 2'b00;
   int          m_cnt = 0;
   logic [7:0]  m_thr = '0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [23:0] v, input int c);
      exp_t e;
      e.val = v;
      e.cyc = c;
      return e;
   endfunction

   function automatic logic [7:0] f_gray(input logic [23:0] p);
      int s;
      s = int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0]);
      return 8'(s / 4);
   endfunction

   function automatic logic [7:0] f_mode10(input logic [23:0] p);
      logic [7:0] g;
      g = f_gray(p);
`ifdef PX_MODE_ROUTER_THRESHOLD_EN
      if (m_thr != 0) g = (g >= m_thr) ? 8'hFF : 8'h00;
`endif
      return g;
   endfunction

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk_i) begin : mon
      bit w;
      if (chk_en) begin
         w = (q_out.size() > 0) && (q_out[0].cyc == cyc);
         chk("px_rdy_o", {23'd0, px_rdy_o}, {23'd0, w});
         if (w) begin
            chk("out_pixel_o", out_pixel_o, q_out[0].val);
            last_out = q_out[0].val;
            void'(q_out.pop_front());
         end else begin
            chk("out_hold", out_pixel_o, last_out);
         end
         w = (q_sob.size() > 0) && (q_sob[0].cyc == cyc);
         chk("sobel_rdy_o", {23'd0, sobel_rdy_o}, {23'd0, w});
         if (w) begin
            chk("sobel_px_o", {16'd0, sobel_px_o}, q_sob[0].val);
            void'(q_sob.pop_front());
         end
         w = (q_done.size() > 0) && (q_done[0] == cyc);
         chk("frame_done_o", {23'd0, frame_done_o}, {23'd0, w});
         if (w) void'(q_done.pop_front());
         if (q_mode.size() > 0 && q_mode[0].cyc == cyc) begin
            chk("mode_o", {22'd0, mode_o}, q_mode[0].val);
            void'(q_mode.pop_front());
         end
      end
   end

   task automatic drive(input bit fs, input logic [1:0] md, input bit pv, input logic [23:0] px,
                        input bit sv, input logic [7:0] spx);
      logic [1:0] eff;
      @(posedge clk_i);
      #1;
      frame_start_i = fs;
      mode_i        = md;
      px_rdy_i      = pv;
      in_pixel_i    = px;
      sobel_rdy_i   = sv;
      sobel_px_i    = spx;
      eff = fs ? md : m_mode;
      if (sv && m_mode < 2) q_out.push_back(mk({16'd0, spx}, cyc + 1));
      if (pv) begin
         case (eff)
            2'd0:    q_sob.push_back(mk({16'd0, f_gray(px)}, cyc + 1));
            2'd1:    q_sob.push_back(mk({16'd0, px[7:0]}, cyc + 1));
            2'd2:    q_out.push_back(mk({16'd0, f_mode10(px)}, cyc + 2));
            default: q_out.push_back(mk(px, cyc + 2));
         endcase
      end
      if (fs) begin
         m_cnt = pv ? 1 : 0;
      end else if (pv) begin
         if (m_cnt == FRAME_PX - 1) begin
            m_cnt = 0;
            q_done.push_back(cyc + 1);
         end else begin
            m_cnt++;
         end
      end
      if (fs) m_mode = md;
      q_mode.push_back(mk({22'd0, m_mode}, cyc + 1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 2'($urandom_range(3)), 1'b0, 24'($urandom), 1'b0, 8'($urandom));
   endtask

   task automatic check_reset_outputs();
      chk("rst_out_pixel_o", out_pixel_o, 24'd0);
      chk("rst_px_rdy_o", {23'd0, px_rdy_o}, 24'd0);
      chk("rst_sobel_px_o", {16'd0, sobel_px_o}, 24'd0);
      chk("rst_sobel_rdy_o", {23'd0, sobel_rdy_o}, 24'd0);
      chk("rst_frame_done_o", {23'd0, frame_done_o}, 24'd0);
      chk("rst_mode_o", {22'd0, mode_o}, 24'd0);
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #1;
      chk_en        = 1'b0;
      nreset_i      = 1'b0;
      frame_start_i = 1'b0;
      px_rdy_i      = 1'b0;
      sobel_rdy_i   = 1'b0;
      #1;
      check_reset_outputs();
      q_out.delete();
      q_sob.delete();
      q_mode.delete();
      q_done.delete();
      m_mode   = 2'b00;
      m_cnt    = 0;
      last_out = '0;
      repeat (2) @(posedge clk_i);
      #1;
      nreset_i = 1'b1;
      chk_en   = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_outputs();
      nreset_i = 1'b1;
      chk_en   = 1'b1;
      idle(3);

      // frame start + mode 10 + pixel in the same cycle
      drive(1'b1, 2'd2, 1'b1, 24'h4080C0, 1'b0, 8'h00);
      idle(3);

      // mode 01 latched, mode_i moves to 11 mid-frame
      drive(1'b1, 2'd1, 1'b0, 24'h000000, 1'b0, 8'h00);
      drive(1'b0, 2'd3, 1'b1, 24'h123456, 1'b0, 8'h00);
      idle(1);
      drive(1'b0, 2'd3, 1'b0, 24'h000000, 1'b1, 8'hAB);
      idle(2);

      // frame counting: 4 pixels then a 5th
      drive(1'b1, 2'd3, 1'b0, 24'h000000, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++)
         drive(1'b0, 2'd0, 1'b1, 24'($urandom), 1'b0, 8'h00);
      idle(3);

      // 00 -> 11 switch, late Sobel return must be dropped
      drive(1'b1, 2'd0, 1'b1, 24'h010203, 1'b0, 8'h00);
      drive(1'b1, 2'd3, 1'b0, 24'h000000, 1'b0, 8'h00);
      drive(1'b0, 2'd0, 1'b0, 24'h000000, 1'b1, 8'h77);
      idle(3);

`ifdef PX_MODE_ROUTER_THRESHOLD_EN
      m_thr = 8'h80;
      threshold_i = 8'h80;
      drive(1'b1, 2'd2, 1'b1, 24'h4080C0, 1'b0, 8'h00);
      drive(1'b0, 2'd2, 1'b1, 24'h7F807F, 1'b0, 8'h00);
      idle(3);
      m_thr = 8'h00;
      threshold_i = 8'h00;
      drive(1'b0, 2'd2, 1'b1, 24'h4080C0, 1'b0, 8'h00);
      idle(3);
`endif

      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) begin
            do_reset();
            idle(4);
         end
         if (i % 500 == 0) begin
            idle(3);
            m_thr = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            threshold_i = m_thr;
         end
         drive($urandom_range(7) == 0, 2'($urandom_range(3)), $urandom_range(1) == 1,
               24'($urandom), $urandom_range(2) == 0, 8'($urandom));
      end
      idle(5);
      chk("drain", 24'(q_out.size() + q_sob.size() + q_done.size()), 24'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
